alu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller that drives the 16-bit ALU's control inputs (`op`, `format`, `eq`, `ltgt`) and consumes its `compres` branch-compare result. It sits between instruction memory, the register file and the ALU, and owns the program counter. Each instruction takes three cycles; a branch is taken when the ALU reports `compres`=1.

---
 rtl/alu_seq_pkg.sv | 60 ++++++
 rtl/alu_seq_decode.sv | 64 ++++++
 rtl/alu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: opcode constants, ltgt compare
// encodings, instruction field positions, the FSM state type and the decoded
// control bundle passed from alu_seq_decode to the top.
// Optional feature macro used by the top: ALU_SEQ_PERF_EN.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   // Opcodes (instruction bits [14:11])
   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_BRANCH = 4'd4;
   localparam logic [3:0] OP_EPAR   = 4'd5;
   localparam logic [3:0] OP_HALT   = 4'hF;

   // ALU ltgt compare encodings (two LSBs; bit 2 of the ALU port is always 0)
   localparam logic [1:0] LTGT_EQ = 2'd0;
   localparam logic [1:0] LTGT_LT = 2'd1;
   localparam logic [1:0] LTGT_GT = 2'd2;

   // Instruction field positions
   localparam int unsigned F_FORMAT  = 15;
   localparam int unsigned F_OP_HI   = 14;
   localparam int unsigned F_OP_LO   = 11;
   localparam int unsigned F_EQ      = 10;
   localparam int unsigned F_LTGT_HI = 9;
   localparam int unsigned F_LTGT_LO = 8;
   localparam int unsigned F_RA_HI   = 7;
   localparam int unsigned F_RA_LO   = 4;
   localparam int unsigned F_RB_HI   = 3;
   localparam int unsigned F_RB_LO   = 0;
   localparam int unsigned F_OFF_HI  = 7;
   localparam int unsigned F_OFF_LO  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

   // Control values presented to the ALU / register file during EXEC
   typedef struct packed {
      logic       format;
      logic [3:0] op;
      logic       eq;
      logic [2:0] ltgt;
      logic [3:0] raddr_a;
      logic [3:0] raddr_b;
      logic [3:0] waddr;
      logic       we;
   } ctrl_t;

   // Register-writing ALU operations (valid only with format=1)
   function automatic logic is_write_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_EPAR);
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
// Purely combinational decode of the instruction register into ALU controls,
// register-file addresses and the branch/halt flags used by the sequencer.
// Ports:
//   i_instr      in  16  instruction register contents
//   o_ctrl       out     ALU / register-file control bundle (ctrl_t)
//   o_is_branch  out  1  format=1 BRANCH
//   o_is_halt    out  1  format=0 HALT
// -----------------------------------------------------------------------------
module alu_seq_decode
   import alu_seq_pkg::*;
#(
   parameter logic [3:0] C1_REG = 4'd1,
   parameter logic [3:0] C2_REG = 4'd2
) (
   input  logic [15:0] i_instr,
   output ctrl_t       o_ctrl,
   output logic        o_is_branch,
   output logic        o_is_halt
);

   logic       w_format;
   logic [3:0] w_op;
   logic [3:0] w_ra;
   logic [3:0] w_rb;

   assign w_format = i_instr[F_FORMAT];
   assign w_op     = i_instr[F_OP_HI:F_OP_LO];
   assign w_ra     = i_instr[F_RA_HI:F_RA_LO];
   assign w_rb     = i_instr[F_RB_HI:F_RB_LO];

   // Field extraction and per-opcode address / write-enable selection
   always_comb begin
      o_ctrl        = '0;
      o_is_branch   = 1'b0;
      o_is_halt     = 1'b0;
      o_ctrl.format = w_format;
      o_ctrl.op     = w_op;
      o_ctrl.eq     = i_instr[F_EQ];
      o_ctrl.ltgt   = {1'b0, i_instr[F_LTGT_HI:F_LTGT_LO]};
      if (w_format) begin
         if (w_op == OP_BRANCH) begin
            // Branch compares the two fixed condition registers
            o_ctrl.raddr_a = C1_REG;
            o_ctrl.raddr_b = C2_REG;
            o_is_branch    = 1'b1;
         end else begin
            o_ctrl.raddr_a = w_ra;
            o_ctrl.raddr_b = w_rb;
            if (is_write_op(w_op)) begin
               o_ctrl.waddr = w_ra;
               o_ctrl.we    = 1'b1;
            end else begin
               o_ctrl.waddr = 4'd0;
               o_ctrl.we    = 1'b0;
            end
         end
      end else begin
         o_is_halt = (w_op == OP_HALT);
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Three-cycle FETCH/DECODE/EXEC controller for the 16-bit ALU. Owns the PC,
// presents it to a 1-cycle-latency instruction memory, latches the returned
// word into IR and drives ALU / register-file controls during EXEC. Branches
// are taken on ALU compres=1 at the EXEC edge; HALT returns to IDLE.
// Ports: clock, reset (async, active-high), start, imem_addr/imem_data,
//   rf_raddr_a/rf_raddr_b/rf_waddr/rf_we, op/format/eq/ltgt, compres,
//   halted, pc; with ALU_SEQ_PERF_EN defined also cycle_cnt and instr_cnt.
// Optional feature macro: ALU_SEQ_PERF_EN (saturating 32-bit perf counters).
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int         PC_W   = 8,
   parameter logic [3:0] C1_REG = 4'd1,
   parameter logic [3:0] C2_REG = 4'd2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic [3:0]      rf_raddr_a,
   output logic [3:0]      rf_raddr_b,
   output logic [3:0]      rf_waddr,
   output logic            rf_we,
   output logic [3:0]      op,
   output logic            format,
   output logic            eq,
   output logic [2:0]      ltgt,
   input  logic            compres,
   output logic            halted,
   output logic [PC_W-1:0] pc
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [31:0]     cycle_cnt,
   output logic [31:0]     instr_cnt
`endif
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] w_offset;
   logic [15:0]     r_ir;
   logic            r_halted;
   logic            w_halted_nxt;
   ctrl_t           w_dec;
   ctrl_t           w_ctrl;
   logic            w_is_branch;
   logic            w_is_halt;

   alu_seq_decode #(
      .C1_REG (C1_REG),
      .C2_REG (C2_REG)
   ) u_decode (
      .i_instr     (r_ir),
      .o_ctrl      (w_dec),
      .o_is_branch (w_is_branch),
      .o_is_halt   (w_is_halt)
   );

   // Signed 8-bit offset sign-extended to PC width; PC math wraps naturally
   assign w_offset = PC_W'($signed(r_ir[F_OFF_HI:F_OFF_LO]));

   // Next-state, next-PC and halted-flag logic
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_halted_nxt = r_halted;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt  = ST_FETCH;
               w_halted_nxt = 1'b0;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_FETCH:  w_state_nxt = ST_DECODE;
         ST_DECODE: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (w_is_halt) begin
               // PC stays on the HALT so a restart re-fetches it
               w_state_nxt  = ST_IDLE;
               w_halted_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_FETCH;
               if (w_is_branch && compres) begin
                  w_pc_nxt = r_pc + w_offset;
               end else begin
                  w_pc_nxt = r_pc + PC_W'(1'b1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, PC, IR and halted registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_ir     <= 16'd0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_halted <= w_halted_nxt;
         if (r_state == ST_DECODE) begin
            r_ir <= imem_data;
         end else begin
            r_ir <= r_ir;
         end
      end
   end

   // ALU and register file see decoded controls only in EXEC, idle otherwise
   always_comb begin
      w_ctrl = '0;
      if (r_state == ST_EXEC) begin
         w_ctrl = w_dec;
      end else begin
         w_ctrl = '0;
      end
   end

   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign halted     = r_halted;
   assign op         = w_ctrl.op;
   assign format     = w_ctrl.format;
   assign eq         = w_ctrl.eq;
   assign ltgt       = w_ctrl.ltgt;
   assign rf_raddr_a = w_ctrl.raddr_a;
   assign rf_raddr_b = w_ctrl.raddr_b;
   assign rf_waddr   = w_ctrl.waddr;
   assign rf_we      = w_ctrl.we;

`ifdef ALU_SEQ_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   // Saturating busy-cycle and executed-instruction counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else begin
         if ((r_state != ST_IDLE) && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         end else begin
            r_cycle_cnt <= r_cycle_cnt;
         end
         if ((r_state == ST_EXEC) && (r_instr_cnt != 32'hFFFF_FFFF)) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
         end else begin
            r_instr_cnt <= r_instr_cnt;
         end
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. A bench-side instruction memory with
// one-cycle read latency feeds the DUT; a reference model tracks the PC and
// halted flag from the instruction semantics and predicts EXEC-cycle controls.
// Perf-counter checks are compiled in when ALU_SEQ_PERF_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data = 16'd0;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic        rf_we;
   logic [3:0]  op;
   logic        format;
   logic        eq;
   logic [2:0]  ltgt;
   logic        compres = 1'b0;
   logic        halted;
   logic [7:0]  pc;
`ifdef ALU_SEQ_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] imem [0:255];
   int          m_pc;
   logic        m_halted;

   alu_sequencer #(.PC_W(8), .C1_REG(4'd1), .C2_REG(4'd2)) dut (
      .clock(clock), .reset(reset), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_waddr(rf_waddr), .rf_we(rf_we),
      .op(op), .format(format), .eq(eq), .ltgt(ltgt),
      .compres(compres), .halted(halted), .pc(pc)
`ifdef ALU_SEQ_PERF_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   always #5 clock = ~clock;

   // synchronous instruction memory, one-cycle latency
   always @(posedge clock) imem_data <= imem[imem_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Assert reset asynchronously (called at a negedge), check, release.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      n_checks++;
      if ({imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, op, format, eq, ltgt, halted, pc} !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got addr=%h ra=%h rb=%h wa=%h we=%b op=%h fmt=%b eq=%b ltgt=%h halted=%b pc=%h, want all 0",
                  imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, op, format, eq, ltgt, halted, pc);
      end
      @(negedge clock);
      reset    = 1'b0;
      m_pc     = 0;
      m_halted = 1'b0;
   endtask

   // Pulse start from IDLE (called at a negedge); returns in the FETCH cycle.
   task automatic do_start();
      start = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      m_halted = 1'b0;
      n_checks++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL start_clears_halted: got %b want 0", halted);
      end
   endtask

   // Run one instruction from its FETCH cycle and compare with the model.
   task automatic exec_one(input logic [15:0] instr, input logic cmp, input logic poke_start);
      logic       fmt, writes, branch, halt;
      logic [3:0] opc;
      int         off, nxt;
      fmt    = instr[15];
      opc    = instr[14:11];
      writes = fmt && (opc == 4'd0 || opc == 4'd1 || opc == 4'd5);
      branch = fmt && (opc == 4'd4);
      halt   = !fmt && (opc == 4'hF);
      off    = instr[7] ? int'(instr[7:0]) - 256 : int'(instr[7:0]);
      if (halt)                nxt = m_pc;
      else if (branch && cmp)  nxt = (m_pc + off + 256) % 256;
      else                     nxt = (m_pc + 1) % 256;
      imem[m_pc] = instr;
      // FETCH cycle
      n_checks++;
      if ({imem_addr, pc, rf_we, format} !== {m_pc[7:0], m_pc[7:0], 2'b00}) begin
         n_fail++;
         $display("FAIL fetch: got addr=%h pc=%h we=%b fmt=%b want addr=pc=%h we=0 fmt=0", imem_addr, pc, rf_we, format, m_pc[7:0]);
      end
      @(negedge clock);
      // DECODE cycle
      n_checks++;
      if ({rf_we, format} !== 2'b00) begin
         n_fail++;
         $display("FAIL decode_idle: got we=%b fmt=%b want 0 0", rf_we, format);
      end
      compres = cmp;
      start   = poke_start;
      @(negedge clock);
      start = 1'b0;
      // EXEC cycle
      n_checks++;
      if ({format, op, eq, ltgt, rf_we} !== {fmt, opc, instr[10], 1'b0, instr[9:8], writes}) begin
         n_fail++;
         $display("FAIL exec_ctrl instr=%h: got fmt=%b op=%h eq=%b ltgt=%h we=%b want fmt=%b op=%h eq=%b ltgt=%h we=%b",
                  instr, format, op, eq, ltgt, rf_we, fmt, opc, instr[10], {1'b0, instr[9:8]}, writes);
      end
      if (writes) begin
         n_checks++;
         if ({rf_raddr_a, rf_raddr_b, rf_waddr} !== {instr[7:4], instr[3:0], instr[7:4]}) begin
            n_fail++;
            $display("FAIL exec_addr instr=%h: got a=%h b=%h w=%h want a=%h b=%h w=%h",
                     instr, rf_raddr_a, rf_raddr_b, rf_waddr, instr[7:4], instr[3:0], instr[7:4]);
         end
      end
      if (branch) begin
         n_checks++;
         if ({rf_raddr_a, rf_raddr_b} !== {4'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL branch_addr instr=%h: got a=%h b=%h want 1 2", instr, rf_raddr_a, rf_raddr_b);
         end
      end
      @(negedge clock);
      compres  = 1'b0;
      m_pc     = nxt;
      m_halted = halt;
      // following cycle: next FETCH, or IDLE after HALT
      n_checks++;
      if ({pc, imem_addr, halted, rf_we} !== {m_pc[7:0], m_pc[7:0], m_halted, 1'b0}) begin
         n_fail++;
         $display("FAIL next_pc instr=%h cmp=%b: got pc=%h addr=%h halted=%b we=%b want pc=%h halted=%b we=0",
                  instr, cmp, pc, imem_addr, halted, rf_we, m_pc[7:0], m_halted);
      end
   endtask

   task automatic test_reset();
      do_reset();
      imem[0] = 16'h8034;
      do_start();
      @(negedge clock);   // now in DECODE
      do_reset();         // abort mid-instruction
      do_start();
      exec_one(16'h8034, 1'b0, 1'b0);  // ADD r3,r4 from address 0
   endtask

   task automatic test_start_reset_coincident();
      @(negedge clock);
      do_reset();
      imem[0] = 16'h8034;
      start = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      start = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({rf_we, format, imem_addr} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL start_reset_coincident cyc %0d: got we=%b fmt=%b addr=%h want idle at 0", i, rf_we, format, imem_addr);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_branch();
      do_reset();
      do_start();
      for (int i = 0; i < 5; i++) exec_one(16'h0000, 1'b0, 1'b0);   // NOPs to PC=5
      exec_one(16'hA4FE, 1'b1, 1'b0);                                // taken -2 -> 3
      exec_one(16'h0000, 1'b0, 1'b0);
      exec_one(16'h0000, 1'b0, 1'b0);                                // back at 5
      exec_one(16'hA4FE, 1'b0, 1'b1);                                // not taken -> 6, start ignored
   endtask

   task automatic test_wrap();
      exec_one(16'hA47F, 1'b1, 1'b0);  // 6 + 127 = 133
      exec_one(16'hA47A, 1'b1, 1'b0);  // 133 + 122 = 255
      exec_one(16'hA401, 1'b1, 1'b0);  // 255 + 1 wraps to 0
   endtask

   task automatic test_halt();
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) exec_one(16'h0000, 1'b0, 1'b0);
      exec_one(16'h7800, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if ({halted, imem_addr, pc, rf_we} !== {1'b1, 8'd4, 8'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_idle: got halted=%b addr=%h pc=%h we=%b want 1 04 04 0", halted, imem_addr, pc, rf_we);
         end
      end
      do_start();
      exec_one(16'h0000, 1'b0, 1'b0);  // refetch at 4
   endtask

   task automatic test_random();
      logic [15:0] instr;
      do_reset();
      do_start();
      for (int i = 0; i < 80; i++) begin
         instr = 16'($urandom);
         if ($urandom_range(0, 3) == 0) instr[15:11] = 5'b1_0100;   // bias to BRANCH
         if ($urandom_range(0, 15) == 0) instr[15:11] = 5'b0_1111;  // occasional HALT
         exec_one(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (m_halted) do_start();
      end
   endtask

`ifdef ALU_SEQ_PERF_EN
   task automatic test_perf();
      do_reset();
      do_start();
      exec_one(16'h8034, 1'b0, 1'b0);
      exec_one(16'h0000, 1'b0, 1'b0);
      exec_one(16'h7800, 1'b0, 1'b0);
      n_checks++;
      if ({instr_cnt, cycle_cnt} !== {32'd3, 32'd9}) begin
         n_fail++;
         $display("FAIL perf_counts: got instr=%0d cycles=%0d want 3 9", instr_cnt, cycle_cnt);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      m_pc     = 0;
      m_halted = 1'b0;
      @(negedge clock);
      test_reset();
      test_start_reset_coincident();
      test_branch();
      test_wrap();
      test_halt();
      test_random();
`ifdef ALU_SEQ_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
